rom_burst_streamer: RTL and testbench
=====================================

# rom_burst_streamer

Parametrised frame streamer that walks a pixel ROM in row/column order and pushes words into an internal single-clock FIFO, one burst at a time whenever the fill level drops below a low watermark. The SDRAM write controller drains the FIFO through a read-enable and receives zero-extended 16-bit words. It sits between the image ROM and the SDRAM controller. It replaces the fixed 3-bit, dual-clock ROM-to-FIFO path with configurable geometry, width, depth, burst size and ROM latency, and adds frame sequencing and error flags.

## Interface
- DATA_W, 3: ROM data width; must be ≤ OUT_W.
- OUT_W, 16: output word width; upper OUT_W-DATA_W bits are 0.
- ADDR_W, 16: ROM address width.
- H_ACT, 128: pixels per row.
- V_ACT, 128: rows per frame; H_ACT*V_ACT ≤ 2^ADDR_W.
- DEPTH, 1024: FIFO depth, power of 2; AW = log2(DEPTH).
- BURST_LEN, 255: ROM reads per burst.
- LOW_WM, 512: a burst starts only when used_o < LOW_WM. Requires LOW_WM + BURST_LEN ≤ DEPTH.
- ROM_LAT, 1: ROM address-to-data latency in cycles, ≥ 1.
- clk_100M_i  in  1  sole clock.
- rst_100i  in  1  reset, asynchronous, active-high.
- start_i  in  1  1-cycle pulse; starts a frame from IDLE, ignored otherwise.
- clr_i  in  1  synchronous clear of FIFO, FSM, counters and flags.
- rom_add_o  out  ADDR_W  ROM read address.
- rom_dat_i  in  DATA_W  ROM data, valid ROM_LAT cycles after its address.
- rd_en_i  in  1  FIFO pop request from the SDRAM writer.
- rd_data_o  out  OUT_W  popped word, registered.
- used_o  out  AW+1  FIFO occupancy, 0..DEPTH.
- burst_rdy_o  out  1  high while used_o ≥ BURST_LEN.
- busy_o  out  1  high in any state except IDLE.
- frame_done_o  out  1  1-cycle pulse when the final pixel is written to the FIFO.
- ovf_o / udf_o  out  1  sticky: write while full / rd_en_i while empty.

## Operation
- States:
  - IDLE: on start_i, go to CHECK; the pixel counter (rem) loads H_ACT*V_ACT and the address loads 0.
  - CHECK:
    - rem = 0 → DONE.
    - rem > 0 and used_o < LOW_WM → FETCH; the burst counter loads min(BURST_LEN, rem).
    - Otherwise stay in CHECK.
  - FETCH: each cycle issue rom_add_o, then increment the address and decrement rem and the burst counter. The column counter wraps at H_ACT-1 and increments the row. When the burst counter reaches 0 → DRAIN.
  - DRAIN: wait until the ROM_LAT-deep valid shift register is empty, then → CHECK.
  - DONE: pulse frame_done_o, then → IDLE.
- The valid pipeline is ROM_LAT stages. Its output writes {0, rom_dat_i} into the FIFO.
- FIFO:
  - Circular buffer with AW-bit write and read pointers, plus an AW+1-bit count.
  - Write with read in the same cycle leaves the count unchanged.
  - A write when count = DEPTH is dropped and sets ovf_o. This is unreachable if the parameter rule holds.
  - rd_en_i when count = 0 is ignored: rd_data_o holds, udf_o is set.
- Pointers wrap modulo DEPTH. The ROM address never exceeds H_ACT*V_ACT-1 and returns to 0 on the next start.
- clr_i has priority over all other inputs and clears everything, as reset does. A clear mid-frame abandons the frame, and pending ROM data is discarded.

## Timing
- Reset and clr_i values: all outputs 0; FSM in IDLE; FIFO empty.
- Frame start: start_i at cycle t → CHECK at t+1 → FETCH at t+2 with rom_add_o = 0. Addresses 0,1,2,… are issued on consecutive cycles.
- Fill path: the address issued at cycle k is written at edge k+ROM_LAT, and used_o increments in that same cycle (visible at k+ROM_LAT+1).
- Pop: rd_en_i at cycle r (non-empty) → rd_data_o valid at r+1. used_o decrements at r+1.
- burst_rdy_o and busy_o are registered and updated with used_o and the state.
- Burst gap: after the last FETCH cycle there are ROM_LAT DRAIN cycles plus 1 CHECK cycle before the next FETCH.
- frame_done_o: asserted the cycle after the final FIFO write (DONE); busy_o falls the following cycle.

## Test plan
All scenarios use the small config: H_ACT=16, V_ACT=4, DEPTH=32, BURST_LEN=8, LOW_WM=16, ROM_LAT=2. The ROM returns addr[2:0].
- Reset check: assert rst_100i mid-cycle, then release → all outputs 0, busy_o 0, rom_add_o 0. start_i then produces the first address at exactly t+2.
- Fill without draining, rd_en_i held 0 → bursts of 8 repeat until used_o = 16, then FSM holds in CHECK. used_o peaks at 16 (never 24); burst_rdy_o goes high once used_o reaches 8.
- Full frame with rd_en_i = 1 whenever burst_rdy_o = 1 → 64 words out, values cycling 0..7. frame_done_o pulses once, ovf_o = 0, udf_o = 0.
- Simultaneous read and write at used_o = 10 → used_o stays 10; popped data is the oldest entry.
- rd_en_i with an empty FIFO → udf_o = 1 and stays 1; rd_data_o unchanged; used_o stays 0.
- clr_i during FETCH at rom_add_o = 5 → next cycle: IDLE, used_o = 0, flags 0. Late ROM data is discarded. A new start_i restarts the frame at address 0.

Source files
------------

// File: rtl/rom_burst_streamer.sv
// rom_burst_streamer: walks a pixel ROM in row-major order and refills an
// internal single-clock FIFO one burst at a time whenever its fill level
// drops below LOW_WM. The downstream writer pops zero-extended words.
//
// Ports:
//   clk_100M_i    sole clock
//   rst_100i      asynchronous active-high reset
//   start_i       1-cycle pulse, starts a frame from IDLE
//   clr_i         synchronous clear of FIFO, FSM, counters and flags
//   rom_add_o     ROM read address
//   rom_dat_i     ROM data, valid ROM_LAT cycles after its address
//   rd_en_i       FIFO pop request
//   rd_data_o     popped word (registered)
//   used_o        FIFO occupancy 0..DEPTH
//   burst_rdy_o   used_o >= BURST_LEN
//   busy_o        FSM not in IDLE
//   frame_done_o  1-cycle pulse once the frame's last word is in the FIFO
//   ovf_o, udf_o  sticky overflow / underflow flags
module rom_burst_streamer #(
  parameter int unsigned DATA_W    = 3,
  parameter int unsigned OUT_W     = 16,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned H_ACT     = 128,
  parameter int unsigned V_ACT     = 128,
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned BURST_LEN = 255,
  parameter int unsigned LOW_WM    = 512,
  parameter int unsigned ROM_LAT   = 1,
  localparam int unsigned AW       = $clog2(DEPTH)
) (
  input  logic              clk_100M_i,
  input  logic              rst_100i,
  input  logic              start_i,
  input  logic              clr_i,
  output logic [ADDR_W-1:0] rom_add_o,
  input  logic [DATA_W-1:0] rom_dat_i,
  input  logic              rd_en_i,
  output logic [OUT_W-1:0]  rd_data_o,
  output logic [AW:0]       used_o,
  output logic              burst_rdy_o,
  output logic              busy_o,
  output logic              frame_done_o,
  output logic              ovf_o,
  output logic              udf_o
);

  localparam int unsigned RW = ADDR_W + 1;
  localparam int unsigned BW = $clog2(BURST_LEN + 1);

  localparam logic [RW-1:0]      FRAME_PIX = RW'(H_ACT * V_ACT);
  localparam logic [RW-1:0]      BURST_R   = RW'(BURST_LEN);
  localparam logic [AW:0]        DEPTH_C   = (AW + 1)'(DEPTH);
  localparam logic [AW:0]        LOW_C     = (AW + 1)'(LOW_WM);
  localparam logic [AW:0]        BURST_C   = (AW + 1)'(BURST_LEN);
  localparam logic [ROM_LAT-1:0] VLD_TOP   = ROM_LAT'(1 << (ROM_LAT - 1));

  typedef enum logic [2:0] {IDLE, CHECK, FETCH, DRAIN, DONE} state_t;

  state_t             state;
  logic [RW-1:0]      rem;
  logic [BW-1:0]      bcnt;
  logic [ROM_LAT-1:0] vld;

  logic [OUT_W-1:0]   mem [DEPTH];
  logic [AW-1:0]      wptr;
  logic [AW-1:0]      rptr;

  logic               wr;
  logic               wr_ok;
  logic               rd_ok;
  logic [AW:0]        used_nxt;

  // FIFO write/read qualification and next occupancy
  always_comb begin
    wr       = vld[ROM_LAT-1];
    wr_ok    = wr && (used_o != DEPTH_C);
    rd_ok    = rd_en_i && (used_o != '0);
    used_nxt = used_o + (AW + 1)'(wr_ok) - (AW + 1)'(rd_ok);
  end

  // Frame sequencer: burst issue, ROM valid pipeline, status outputs
  always_ff @(posedge clk_100M_i or posedge rst_100i) begin
    if (rst_100i) begin
      state        <= IDLE;
      rem          <= '0;
      bcnt         <= '0;
      vld          <= '0;
      rom_add_o    <= '0;
      busy_o       <= 1'b0;
      frame_done_o <= 1'b0;
    end else if (clr_i) begin
      // clearing the valid pipe drops ROM data still in flight
      state        <= IDLE;
      rem          <= '0;
      bcnt         <= '0;
      vld          <= '0;
      rom_add_o    <= '0;
      busy_o       <= 1'b0;
      frame_done_o <= 1'b0;
    end else begin
      vld          <= ROM_LAT'({vld, state == FETCH});
      frame_done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            state     <= CHECK;
            rem       <= FRAME_PIX;
            rom_add_o <= '0;
            busy_o    <= 1'b1;
          end
        end
        CHECK: begin
          if (rem == '0) begin
            state        <= DONE;
            frame_done_o <= 1'b1;
          end else if (used_o < LOW_C) begin
            state <= FETCH;
            bcnt  <= (rem < BURST_R) ? BW'(rem) : BW'(BURST_LEN);
          end
        end
        FETCH: begin
          // linear address == row*H_ACT + col for a row-major walk;
          // held at the last pixel so it never runs past the frame
          rem  <= rem - RW'(1);
          bcnt <= bcnt - BW'(1);
          if (rem > RW'(1)) rom_add_o <= rom_add_o + ADDR_W'(1);
          if (bcnt == BW'(1)) state <= DRAIN;
        end
        DRAIN: begin
          // leave once only the last stage is occupied: its write lands this
          // edge, so CHECK sees an up-to-date used_o
          if ((vld & ~VLD_TOP) == '0) state <= CHECK;
        end
        DONE: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

  // FIFO pointers, occupancy, read data and sticky flags
  always_ff @(posedge clk_100M_i or posedge rst_100i) begin
    if (rst_100i) begin
      wptr        <= '0;
      rptr        <= '0;
      used_o      <= '0;
      rd_data_o   <= '0;
      burst_rdy_o <= 1'b0;
      ovf_o       <= 1'b0;
      udf_o       <= 1'b0;
    end else if (clr_i) begin
      wptr        <= '0;
      rptr        <= '0;
      used_o      <= '0;
      rd_data_o   <= '0;
      burst_rdy_o <= 1'b0;
      ovf_o       <= 1'b0;
      udf_o       <= 1'b0;
    end else begin
      if (wr_ok) wptr <= wptr + AW'(1);
      if (rd_ok) begin
        rptr      <= rptr + AW'(1);
        rd_data_o <= mem[rptr];
      end
      used_o      <= used_nxt;
      burst_rdy_o <= (used_nxt >= BURST_C);
      if (wr && !wr_ok)      ovf_o <= 1'b1;
      if (rd_en_i && !rd_ok) udf_o <= 1'b1;
    end
  end

  // FIFO storage, zero-extended ROM words
  always_ff @(posedge clk_100M_i) begin
    if (wr_ok && !clr_i) mem[wptr] <= OUT_W'(rom_dat_i);
  end

endmodule

// File: tb/tb_rom_burst_streamer.sv
// Self-checking bench for rom_burst_streamer in the small configuration
// (16x4 frame, 32-deep FIFO, bursts of 8, watermark 16, ROM latency 2).
// The ROM model returns addr[2:0]; expected FIFO words are queued at frame
// start and compared as they are popped.
module tb_rom_burst_streamer;

  localparam int unsigned DATA_W    = 3;
  localparam int unsigned OUT_W     = 16;
  localparam int unsigned ADDR_W    = 16;
  localparam int unsigned H_ACT     = 16;
  localparam int unsigned V_ACT     = 4;
  localparam int unsigned DEPTH     = 32;
  localparam int unsigned BURST_LEN = 8;
  localparam int unsigned LOW_WM    = 16;
  localparam int unsigned ROM_LAT   = 2;
  localparam int unsigned AW        = $clog2(DEPTH);
  localparam int          NPIX      = H_ACT * V_ACT;

  logic              clk;
  logic              rst;
  logic              start;
  logic              clr;
  logic [ADDR_W-1:0] rom_add;
  logic [DATA_W-1:0] rom_dat;
  logic              rd_en;
  logic [OUT_W-1:0]  rd_data;
  logic [AW:0]       used;
  logic              burst_rdy;
  logic              busy;
  logic              frame_done;
  logic              ovf;
  logic              udf;

  int total = 0;
  int bad   = 0;
  logic [OUT_W-1:0] sb_q[$];

  rom_burst_streamer #(
    .DATA_W(DATA_W), .OUT_W(OUT_W), .ADDR_W(ADDR_W), .H_ACT(H_ACT),
    .V_ACT(V_ACT), .DEPTH(DEPTH), .BURST_LEN(BURST_LEN), .LOW_WM(LOW_WM),
    .ROM_LAT(ROM_LAT)
  ) dut (
    .clk_100M_i  (clk),
    .rst_100i    (rst),
    .start_i     (start),
    .clr_i       (clr),
    .rom_add_o   (rom_add),
    .rom_dat_i   (rom_dat),
    .rd_en_i     (rd_en),
    .rd_data_o   (rd_data),
    .used_o      (used),
    .burst_rdy_o (burst_rdy),
    .busy_o      (busy),
    .frame_done_o(frame_done),
    .ovf_o       (ovf),
    .udf_o       (udf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // two-stage ROM model: data = addr[2:0], ROM_LAT cycles after the address
  logic [2:0] rom_p1;
  logic [2:0] rom_p2;
  always @(posedge clk) begin
    rom_p1 <= rom_add[2:0];
    rom_p2 <= rom_p1;
  end
  assign rom_dat = rom_p2;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic load_frame();
    sb_q.delete();
    for (int n = 0; n < NPIX; n++) sb_q.push_back(OUT_W'(n % 8));
  endtask

  task automatic check_pop(input string tag);
    if (sb_q.size() == 0) chk({tag, "_sb_empty"}, 32'(1), 32'(0));
    else                  chk(tag, 32'(rd_data), 32'(sb_q.pop_front()));
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_used"},  32'(used),       32'(0));
    chk({tag, "_busy"},  32'(busy),       32'(0));
    chk({tag, "_addr"},  32'(rom_add),    32'(0));
    chk({tag, "_brdy"},  32'(burst_rdy),  32'(0));
    chk({tag, "_done"},  32'(frame_done), 32'(0));
    chk({tag, "_ovf"},   32'(ovf),        32'(0));
    chk({tag, "_udf"},   32'(udf),        32'(0));
  endtask

  // expected occupancy c cycles after the start-sampling edge (no reads)
  function automatic int exp_used(input int c);
    if (c < 5)   return 0;
    if (c <= 12) return c - 4;
    if (c <= 15) return 8;
    if (c <= 23) return c - 7;
    return 16;
  endfunction

  // expected ROM address c cycles after the start-sampling edge (no reads)
  function automatic int exp_addr(input int c);
    if (c <= 2)  return 0;
    if (c <= 9)  return c - 2;
    if (c <= 12) return 8;
    if (c <= 20) return c - 5;
    return 16;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  peak;
    int  popped;
    int  done_cnt;
    bit  done_seen;
    bit  rd_prev;
    bit  found;

    rst   = 1'b0;
    start = 1'b0;
    clr   = 1'b0;
    rd_en = 1'b0;

    // reset asserted and released mid-cycle
    #12 rst = 1'b1;
    #10 rst = 1'b0;
    tick();
    check_idle("rst");
    chk("rst_rdata", 32'(rd_data), 32'(0));

    // fill without draining: exact per-cycle used/address/burst_rdy timeline
    load_frame();
    pulse_start();
    peak = 0;
    for (int c = 1; c <= 40; c++) begin
      chk($sformatf("fill_used_c%0d", c), 32'(used),      32'(exp_used(c)));
      chk($sformatf("fill_addr_c%0d", c), 32'(rom_add),   32'(exp_addr(c)));
      chk($sformatf("fill_brdy_c%0d", c), 32'(burst_rdy), 32'(exp_used(c) >= 8));
      chk($sformatf("fill_busy_c%0d", c), 32'(busy),      32'(1));
      if (int'(used) > peak) peak = int'(used);
      tick();
    end
    chk("fill_peak", 32'(peak), 32'(16));

    // simultaneous read and write with used_o = 10
    pulse_clr();
    check_idle("clr1");
    load_frame();
    pulse_start();
    for (int c = 1; c < 17; c++) tick();
    chk("rw_used_before", 32'(used), 32'(10));
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("rw_used_same", 32'(used), 32'(10));
    check_pop("rw_oldest");
    tick();
    chk("rw_used_after", 32'(used), 32'(11));

    // full frame, popping whenever burst_rdy_o, then drain the tail
    pulse_clr();
    check_idle("clr2");
    load_frame();
    pulse_start();
    popped    = 0;
    done_cnt  = 0;
    done_seen = 1'b0;
    rd_prev   = 1'b0;
    for (int i = 0; i < 3000 && popped < NPIX; i++) begin
      if (rd_prev) begin
        check_pop($sformatf("frame_w%0d", popped));
        popped++;
      end
      if (frame_done) begin
        done_cnt++;
        done_seen = 1'b1;
      end
      if (popped < NPIX) rd_en = burst_rdy || (done_seen && used != '0);
      else               rd_en = 1'b0;
      rd_prev = rd_en;
      tick();
    end
    rd_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (frame_done) done_cnt++;
      tick();
    end
    chk("frame_popped",    32'(popped),      32'(NPIX));
    chk("frame_done_cnt",  32'(done_cnt),    32'(1));
    chk("frame_ovf",       32'(ovf),         32'(0));
    chk("frame_udf",       32'(udf),         32'(0));
    chk("frame_busy_end",  32'(busy),        32'(0));
    chk("frame_used_end",  32'(used),        32'(0));
    chk("frame_sb_left",   32'(sb_q.size()), 32'(0));
    chk("frame_last_data", 32'(rd_data),     32'(7));

    // pop while empty: sticky underflow, data held
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("udf_set",   32'(udf),     32'(1));
    chk("udf_rdata", 32'(rd_data), 32'(7));
    chk("udf_used",  32'(used),    32'(0));
    for (int i = 0; i < 5; i++) tick();
    chk("udf_sticky", 32'(udf), 32'(1));
    pulse_clr();
    chk("udf_clr", 32'(udf), 32'(0));

    // clear mid-FETCH at address 5, late ROM data must not land
    load_frame();
    pulse_start();
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (rom_add == ADDR_W'(5)) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk("clr_found_addr5", 32'(found), 32'(1));
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check_idle("clr_mid");
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("clr_late_used%0d", i), 32'(used), 32'(0));
    end
    load_frame();
    pulse_start();
    chk("restart_addr_c1", 32'(rom_add), 32'(0));
    tick();
    chk("restart_addr_c2", 32'(rom_add), 32'(0));
    chk("restart_busy",    32'(busy),    32'(1));
    tick();
    chk("restart_addr_c3", 32'(rom_add), 32'(1));
    tick();
    tick();
    chk("restart_used_c5", 32'(used), 32'(1));
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check_pop("restart_first");
    chk("restart_used_c6", 32'(used), 32'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
